// File: rtl/msk_rnd_pkg.sv
// Shared constants, FSM state type and LFSR feedback helper for the masking
// randomness source.
package msk_rnd_pkg;

    localparam int LFSR_W     = 64;
    localparam int TAP_A      = 63;
    localparam int TAP_B      = 62;
    localparam int TAP_C      = 60;
    localparam int TAP_D      = 59;
    localparam int SEED_BYTES = 8;
    localparam int BYTE_CNT_W = 3;
    localparam int WARM_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Feedback bit for x^64+x^63+x^61+x^60+1
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr64_stepn.sv
// Combinational n-step unroll of the 64-bit Fibonacci LFSR; the generated
// bits come out with the oldest in bits_out[n-1].
module lfsr64_stepn
    import msk_rnd_pkg::*;
#(
    parameter int n = 1
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out,
    output logic [n-1:0]      bits_out
);

    always_comb begin : unroll
        logic [LFSR_W-1:0] s;
        logic              fb;
        s        = state_in;
        fb       = 1'b0;
        bits_out = '0;
        for (int i = 0; i < n; i++) begin
            fb              = lfsr_fb(s);
            s               = {s[LFSR_W-2:0], fb};
            bits_out[n-1-i] = fb;
        end
        state_out = s;
    end

endmodule

// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for HPC1 gadgets: byte-seeded 64-bit LFSR with a
// warm-up phase, then one rnd_width word per valid/ready handshake.
module msk_rnd_source
    import msk_rnd_pkg::*;
#(
    parameter int security_order = 2,
    parameter int rnd_width      = security_order * (security_order + 1),
    parameter int warmup_cycles  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           seed_in,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic                 reseed,
    output logic [rnd_width-1:0] rnd,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 busy
);

    state_e                  state_q, state_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WARM_CNT_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic [rnd_width-1:0]    rnd_q, rnd_d;
    logic                    rnd_valid_q, rnd_valid_d;
    logic                    seed_ready_q, seed_ready_d;

    logic [LFSR_W-1:0]       step1_state;
    logic [0:0]              step1_bit;
    logic [LFSR_W-1:0]       stepn_state;
    logic [rnd_width-1:0]    stepn_bits;
    logic [LFSR_W-1:0]       seed_shift;

    logic                    seed_fire;
    logic                    last_byte;
    logic                    warm_done;
    logic                    handshake;

    lfsr64_stepn #(.n(1)) u_step1 (
        .state_in  (lfsr_q),
        .state_out (step1_state),
        .bits_out  (step1_bit)
    );

    lfsr64_stepn #(.n(rnd_width)) u_stepn (
        .state_in  (lfsr_q),
        .state_out (stepn_state),
        .bits_out  (stepn_bits)
    );

    assign seed_fire  = seed_valid && seed_ready_q;
    assign last_byte  = (byte_cnt_q == BYTE_CNT_W'(SEED_BYTES - 1));
    assign warm_done  = (warm_cnt_q == WARM_CNT_W'(warmup_cycles));
    assign handshake  = rnd_valid_q && rnd_ready;
    assign seed_shift = {lfsr_q[LFSR_W-9:0], seed_in};

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEED;
            byte_cnt_q   <= '0;
            warm_cnt_q   <= '0;
            lfsr_q       <= '0;
            rnd_q        <= '0;
            rnd_valid_q  <= 1'b0;
            seed_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            lfsr_q       <= lfsr_d;
            rnd_q        <= rnd_d;
            rnd_valid_q  <= rnd_valid_d;
            seed_ready_q <= seed_ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEED: begin
                if (!reseed && seed_fire && last_byte) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (reseed)         state_d = ST_SEED;
                else if (warm_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (reseed) state_d = ST_SEED;
            end
            default: state_d = ST_SEED;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        warm_cnt_d   = warm_cnt_q;
        lfsr_d       = lfsr_q;
        rnd_d        = rnd_q;
        rnd_valid_d  = (state_d == ST_RUN);
        seed_ready_d = (state_d == ST_SEED);
        case (state_q)
            ST_SEED: begin
                if (reseed) begin
                    byte_cnt_d = '0;
                end else if (seed_fire) begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    lfsr_d     = seed_shift;
                    if (last_byte) begin
                        warm_cnt_d = '0;
                        // An all-zero seed would lock the LFSR forever
                        if (seed_shift == '0) lfsr_d = LFSR_W'(1);
                    end
                end
            end
            ST_WARMUP: begin
                if (reseed) begin
                    byte_cnt_d = '0;
                    rnd_d      = '0;
                end else if (!warm_done) begin
                    lfsr_d     = {step1_state[LFSR_W-1:1], step1_bit};
                    warm_cnt_d = warm_cnt_q + WARM_CNT_W'(1);
                end else begin
                    lfsr_d = stepn_state;
                    rnd_d  = stepn_bits;
                end
            end
            ST_RUN: begin
                // A handshake coinciding with reseed is already consumed; just clear
                if (reseed) begin
                    byte_cnt_d = '0;
                    rnd_d      = '0;
                end else if (handshake) begin
                    lfsr_d = stepn_state;
                    rnd_d  = stepn_bits;
                end
            end
            default: begin
                byte_cnt_d = '0;
                rnd_d      = '0;
            end
        endcase
    end

    assign seed_ready = seed_ready_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd        = rnd_q;
    assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_msk_rnd_source.sv
// Bench for msk_rnd_source: three instances (order 2, 1, 3) checked against an
// arithmetic LFSR model; table vectors for RUN handshakes plus seeding corner cases.
module tb_msk_rnd_source;

    localparam int W = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seed_in = 8'h00;
    logic        seed_valid = 1'b0;
    logic        reseed = 1'b0;
    logic [2:0]  rdy = 3'b000;

    logic [5:0]  rnd0;
    logic [1:0]  rnd1;
    logic [11:0] rnd3;
    logic        rv0, rv1, rv3, sr0, sr1, sr3, bz0, bz1, bz3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    msk_rnd_source #(.security_order(2)) u0 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr0),
        .reseed(reseed), .rnd(rnd0), .rnd_valid(rv0), .rnd_ready(rdy[0]), .busy(bz0));
    msk_rnd_source #(.security_order(1)) u1 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr1),
        .reseed(reseed), .rnd(rnd1), .rnd_valid(rv1), .rnd_ready(rdy[1]), .busy(bz1));
    msk_rnd_source #(.security_order(3)) u3 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr3),
        .reseed(reseed), .rnd(rnd3), .rnd_valid(rv3), .rnd_ready(rdy[2]), .busy(bz3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one LFSR per instance, width per handshake from the order
    int          wd[3] = '{6, 2, 12};
    logic [63:0] ms[3];
    logic [63:0] mexp[3];
    logic [63:0] golden[8];

    function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        return s;
    endfunction

    function automatic logic [63:0] lfsr_bits(input logic [63:0] s, input int n);
        logic [63:0] r = 64'd0;
        logic fb;
        for (int i = 0; i < n; i++) begin
            fb = s[63] ^ s[62] ^ s[60] ^ s[59];
            r  = (r << 1) | {63'd0, fb};
            s  = {s[62:0], fb};
        end
        return r;
    endfunction

    task automatic model_seed(input logic [63:0] bytes);
        logic [63:0] s = bytes;
        if (s == 64'd0) s = 64'd1;
        s = lfsr_adv(s, W);
        for (int k = 0; k < 3; k++) begin
            mexp[k] = lfsr_bits(s, wd[k]);
            ms[k]   = lfsr_adv(s, wd[k]);
        end
    endtask

    task automatic model_take(input int k);
        mexp[k] = lfsr_bits(ms[k], wd[k]);
        ms[k]   = lfsr_adv(ms[k], wd[k]);
    endtask

    function automatic logic [63:0] act_rnd(input int k);
        case (k)
            0:       return {58'd0, rnd0};
            1:       return {62'd0, rnd1};
            default: return {52'd0, rnd3};
        endcase
    endfunction

    function automatic logic act_rv(input int k);
        case (k)
            0:       return rv0;
            1:       return rv1;
            default: return rv3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; seed_valid = 1'b0; reseed = 1'b0; rdy = 3'b000;
        tick(); tick();
        chk("rst_rnd_valid", {63'd0, rv0}, 64'd0);
        chk("rst_seed_ready", {63'd0, sr0}, 64'd0);
        chk("rst_busy", {63'd0, bz0}, 64'd1);
        chk("rst_rnd", act_rnd(0), 64'd0);
        rst = 1'b0;
        tick();
        chk("seed_ready_after_rst", {63'd0, sr0}, 64'd1);
    endtask

    // Present n bytes (MSB byte first) and return the cycle of the first acceptance
    task automatic feed(input logic [63:0] bytes, input int n, output int acc);
        int   i = 0;
        int   g = 0;
        logic took;
        acc = 0;
        seed_valid = 1'b1;
        while (i < n && g < 64) begin
            seed_in = bytes[63-8*i -: 8];
            took = sr0;
            tick();
            if (took) begin
                if (i == 0) acc = cyc;
                i++;
            end
            g++;
        end
        seed_valid = 1'b0;
        chk("seed_bytes_accepted", 64'(i), 64'(n));
    endtask

    // Full seeding; rnd_valid must rise 8+W edges after the first acceptance edge
    task automatic seed_all(input logic [63:0] bytes);
        int acc;
        int g = 0;
        bit busy_ok = 1'b1;
        feed(bytes, 8, acc);
        chk("seed_ready_after_8", {63'd0, sr0}, 64'd0);
        while (!rv0 && g < 1000) begin
            if (!bz0) busy_ok = 1'b0;
            tick();
            g++;
        end
        chk("rnd_valid_rise", {63'd0, rv0}, 64'd1);
        chk("warmup_latency", 64'(cyc - acc), 64'(8 + W));
        chk("busy_until_run", {63'd0, busy_ok}, 64'd1);
        chk("busy_in_run", {63'd0, bz0}, 64'd0);
        model_seed(bytes);
    endtask

    task automatic reseed_pulse();
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        chk("reseed_valid_low", {63'd0, rv0}, 64'd0);
        chk("reseed_seed_ready", {63'd0, sr0}, 64'd1);
    endtask

    task automatic consume_golden();
        rdy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("golden_valid", {63'd0, rv0}, 64'd1);
            chk("golden_rnd", act_rnd(0), golden[i]);
            tick();
        end
        rdy[0] = 1'b0;
    endtask

    typedef struct {
        logic rdy;
        logic rsd;
        logic e_valid;
        logic e_sready;
        logic e_busy;
    } vec_t;

    initial begin
        vec_t        tv[8];
        logic [63:0] s;
        logic [63:0] rseed;
        logic        took;
        int          acc;
        int          hs1, hs3, g;
        bit          anynz;

        // RUN handshakes: ready 1,0,0,1,1,0 then reseed with a handshake
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        do_reset();

        // Clean seeding with 01..08; remember the first 8 words
        seed_all(64'h0102030405060708);
        golden[0] = mexp[0];
        s = ms[0];
        for (int i = 1; i < 8; i++) begin
            golden[i] = lfsr_bits(s, 6);
            s = lfsr_adv(s, 6);
        end

        for (int v = 0; v < 8; v++) begin
            rdy[0] = tv[v].rdy;
            reseed = tv[v].rsd;
            took = rv0 && rdy[0];
            if (took) chk("consumed_value", act_rnd(0), mexp[0]);
            tick();
            reseed = 1'b0;
            if (took) model_take(0);
            chk("vec_rnd_valid", {63'd0, rv0}, {63'd0, tv[v].e_valid});
            chk("vec_seed_ready", {63'd0, sr0}, {63'd0, tv[v].e_sready});
            chk("vec_busy", {63'd0, bz0}, {63'd0, tv[v].e_busy});
            if (tv[v].e_valid) chk("vec_rnd_model", act_rnd(0), mexp[0]);
            else               chk("vec_rnd_cleared", act_rnd(0), 64'd0);
        end
        rdy[0] = 1'b0;

        // Reseed with the same bytes reproduces the original sequence
        seed_all(64'h0102030405060708);
        consume_golden();

        // Reset after 4 bytes: partial progress must be discarded
        reseed_pulse();
        feed(64'h0102030405060708, 4, acc);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        seed_all(64'h0102030405060708);
        consume_golden();

        // All-zero seed is forced to 1
        reseed_pulse();
        seed_all(64'h0);
        anynz = 1'b0;
        rdy[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("zero_seed_rnd", act_rnd(0), mexp[0]);
            if (act_rnd(0) != 64'd0) anynz = 1'b1;
            tick();
            model_take(0);
        end
        rdy[0] = 1'b0;
        chk("zero_seed_not_stuck", {63'd0, anynz}, 64'd1);

        // Reseed in SEED drops the byte presented that cycle and restarts the count
        reseed_pulse();
        feed(64'hAABBCC0000000000, 3, acc);
        seed_in = 8'hDD; seed_valid = 1'b1; reseed = 1'b1;
        tick();
        reseed = 1'b0; seed_valid = 1'b0;
        chk("seed_reseed_ready", {63'd0, sr0}, 64'd1);
        rseed = {$urandom(), $urandom()};
        seed_all(rseed);

        // Random-ready run on all three widths
        hs1 = 0; hs3 = 0; g = 0;
        while ((hs1 < 1000 || hs3 < 1000) && g < 5000) begin
            for (int k = 0; k < 3; k++) begin
                chk("rand_valid", {63'd0, act_rv(k)}, 64'd1);
                chk("rand_rnd", act_rnd(k), mexp[k]);
            end
            for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 9) < 7);
            tick();
            for (int k = 0; k < 3; k++) if (rdy[k]) model_take(k);
            if (rdy[1]) hs1++;
            if (rdy[2]) hs3++;
            g++;
        end
        rdy = 3'b000;
        chk("rand_handshake_budget", {63'd0, (hs1 >= 1000 && hs3 >= 1000)}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
